// File: rtl/pmu_ahb_pkg.sv
// Shared types for the PMU AHB command master: bus encodings, command record, FSM states.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pmu_ahb_pkg;

    localparam int PMU_REG_W = 32;

    // HTRANS encodings; this master only ever drives IDLE and NONSEQ.
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // One queued bus command.
    typedef struct packed {
        logic                 write;
        logic [PMU_REG_W-1:0] addr;
        logic [PMU_REG_W-1:0] wdata;
    } cmd_t;

    // Master sequencing: one transfer at a time, no overlap between commands.
    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ADDR,
        MS_DATA,
        MS_RESP
    } mstate_e;

    // A command may go on the bus only if it hits the PMU window and is word aligned.
    function automatic logic addr_ok(input logic [PMU_REG_W-1:0] addr,
                                     input logic [PMU_REG_W-1:0] base,
                                     input logic [PMU_REG_W-1:0] mask);
        return ((addr & ~mask) == base) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pmu_cmd_fifo.sv
// Synchronous FIFO of cmd_t entries with registered full/empty flags.
// Latency: a pushed entry is visible on dout_o the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; full is registered, so a pop never frees space in the same cycle.
module pmu_cmd_fifo
    import pmu_ahb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/pmu_ahb_cmd_master.sv
// AHB-lite master turning a valid/ready command stream into single NONSEQ word transfers to the PMU window.
// Latency: accept edge N -> rsp_valid_o sampled high at N+4 (zero wait), +1 per wait state, N+2 for local rejects.
// Backpressure: cmd_ready_o drops when the CMD_DEPTH-entry FIFO is full; responses hold until rsp_ready_i.
// Optional: define PMU_CMD_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES with an error response.
module pmu_ahb_cmd_master
    import pmu_ahb_pkg::*;
#(
    parameter int                   REG_WIDTH      = 32,
    parameter logic [REG_WIDTH-1:0] HADDR_BASE     = 32'h80100000,
    parameter logic [REG_WIDTH-1:0] HMASK          = 32'h00000fff,
    parameter int                   CMD_DEPTH      = 2,
    parameter int                   TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [REG_WIDTH-1:0] cmd_addr_i,
    input  logic [REG_WIDTH-1:0] cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [REG_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 hsel_o,
    output logic [REG_WIDTH-1:0] haddr_o,
    output logic                 hwrite_o,
    output logic [1:0]           htrans_o,
    output logic [2:0]           hsize_o,
    output logic [2:0]           hburst_o,
    output logic [REG_WIDTH-1:0] hwdata_o,
    input  logic                 hready_i,
    input  logic [1:0]           hresp_i,
    input  logic [REG_WIDTH-1:0] hrdata_i
);

    mstate_e              state_q, state_d;
    logic [REG_WIDTH-1:0] haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [REG_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    cmd_t fifo_din;
    cmd_t fifo_dout;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic tmo_hit;

    assign fifo_din.write = cmd_write_i;
    assign fifo_din.addr  = cmd_addr_i;
    assign fifo_din.wdata = cmd_wdata_i;
    assign cmd_ready_o    = !fifo_full;

    pmu_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i && cmd_ready_o),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PMU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_busy;

    // Count consecutive not-ready cycles of the current transfer; fire on the last allowed one.
    always_comb begin
        bus_busy   = (state_q == MS_ADDR) || (state_q == MS_DATA);
        tmo_hit    = bus_busy && !hready_i && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        wait_cnt_d = (!bus_busy || hready_i || tmo_hit) ? '0 : wait_cnt_q + TW'(1);
    end

    // Wait counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Transfer sequencing: pop, address phase, data phase, hold response until taken.
    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rdata_d  = '0;
                    if (!addr_ok(fifo_dout.addr, HADDR_BASE, HMASK)) begin
                        // Rejected locally: never reaches the bus.
                        err_d   = 1'b1;
                        state_d = MS_RESP;
                    end else begin
                        haddr_d  = fifo_dout.addr;
                        hwrite_d = fifo_dout.write;
                        hwdata_d = fifo_dout.wdata;
                        err_d    = 1'b0;
                        state_d  = MS_ADDR;
                    end
                end
            end
            MS_ADDR: begin
                if (hready_i) begin
                    state_d = MS_DATA;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MS_RESP;
                end
            end
            MS_DATA: begin
                // The first ERROR cycle (hready low) just holds; completion needs hready high.
                if (hready_i) begin
                    if (hresp_i == HRESP_OKAY) begin
                        err_d = 1'b0;
                        if (!hwrite_q) rdata_d = hrdata_i;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                    state_d = MS_RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = MS_RESP;
                end
            end
            MS_RESP: begin
                if (rsp_ready_i) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    // State and transfer registers; reset abandons any transfer and pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign hsel_o      = (state_q == MS_ADDR);
    assign htrans_o    = (state_q == MS_ADDR) ? HT_NONSEQ : HT_IDLE;
    assign haddr_o     = haddr_q;
    assign hwrite_o    = hwrite_q;
    assign hwdata_o    = hwdata_q;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign rsp_valid_o = (state_q == MS_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_pmu_ahb_cmd_master.sv
module tb_pmu_ahb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_write_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic        cmd_ready_o;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        hsel_o, hwrite_o;
    logic [31:0] haddr_o, hwdata_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o, hburst_o;
    logic        hready_i;
    logic [1:0]  hresp_i;
    wire  [31:0] hrdata_i;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];

    // Slave read data: either driven directly, or derived from the latched address.
    logic        auto_rd;
    logic [31:0] hrdata_drv;
    logic [31:0] dp_addr;
    assign hrdata_i = auto_rd ? (32'hA5000000 | {20'h0, dp_addr[11:0]}) : hrdata_drv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (hsel_o && hready_i) dp_addr <= haddr_o;

    pmu_ahb_cmd_master dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .hsel_o      (hsel_o),
        .haddr_o     (haddr_o),
        .hwrite_o    (hwrite_o),
        .htrans_o    (htrans_o),
        .hsize_o     (hsize_o),
        .hburst_o    (hburst_o),
        .hwdata_o    (hwdata_o),
        .hready_i    (hready_i),
        .hresp_i     (hresp_i),
        .hrdata_i    (hrdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, wait (bounded) for ready, return #1 after the accepting edge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic track, input logic [31:0] er, input logic ee);
        int k = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        while (!cmd_ready_o && k < 200) begin
            step();
            k++;
        end
        chk("push_ready", {31'b0, cmd_ready_o}, 32'd1);
        if (track) exp_q.push_back('{er, ee});
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Response scoreboard: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            chk("rsp_pending", {31'b0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
                hs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int k;
        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        rsp_ready_i = 1'b1; hready_i = 1'b1; hresp_i = 2'b00;
        auto_rd = 1'b0; hrdata_drv = 32'h0;

        // Reset state
        step(); step();
        chk("rst_hsel", {31'b0, hsel_o}, 32'd0);
        chk("rst_htrans", {30'b0, htrans_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_hsize", {29'b0, hsize_o}, 32'd2);
        chk("rst_hburst", {29'b0, hburst_o}, 32'd0);
        chk("rst_haddr", haddr_o, 32'd0);
        rst_i = 1'b0;
        step();
        chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);

        // Zero-wait write 0x80100000 <= 2
        push(1'b1, 32'h80100000, 32'h2, 1'b1, 32'h0, 1'b0);
        chk("w0_n_hsel", {31'b0, hsel_o}, 32'd0);
        step();
        chk("w0_addr_hsel", {31'b0, hsel_o}, 32'd1);
        chk("w0_addr_htrans", {30'b0, htrans_o}, 32'd2);
        chk("w0_addr_haddr", haddr_o, 32'h80100000);
        chk("w0_addr_hwrite", {31'b0, hwrite_o}, 32'd1);
        step();
        chk("w0_data_hsel", {31'b0, hsel_o}, 32'd0);
        chk("w0_data_htrans", {30'b0, htrans_o}, 32'd0);
        chk("w0_data_hwdata", hwdata_o, 32'h2);
        chk("w0_data_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        step();
        chk("w0_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        step();
        chk("w0_rsp_done", {31'b0, rsp_valid_o}, 32'd0);

        // Read 0x801000ac with three wait states
        push(1'b0, 32'h801000ac, 32'h0, 1'b1, 32'hcafecafe, 1'b0);
        step();
        chk("r1_addr_hsel", {31'b0, hsel_o}, 32'd1);
        chk("r1_addr_hwrite", {31'b0, hwrite_o}, 32'd0);
        step();
        hready_i = 1'b0;
        step(); step(); step();
        chk("r1_wait_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("r1_wait_hsel", {31'b0, hsel_o}, 32'd0);
        hready_i = 1'b1;
        hrdata_drv = 32'hcafecafe;
        step();
        chk("r1_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        hrdata_drv = 32'h0;
        step();

        // Local rejects: out of window and misaligned
        hrdata_drv = 32'hdeadbeef;
        push(1'b0, 32'h80200000, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("rej0_n_hsel", {31'b0, hsel_o}, 32'd0);
        step();
        chk("rej0_hsel", {31'b0, hsel_o}, 32'd0);
        chk("rej0_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        step();
        push(1'b0, 32'h80100002, 32'h0, 1'b1, 32'h0, 1'b1);
        step();
        chk("rej1_hsel", {31'b0, hsel_o}, 32'd0);
        chk("rej1_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        step();
        hrdata_drv = 32'h0;

        // Two-cycle ERROR on write 0x80100074
        push(1'b1, 32'h80100074, 32'h55, 1'b1, 32'h0, 1'b1);
        step();
        step();
        hready_i = 1'b0;
        hresp_i  = 2'b01;
        step();
        chk("err_first_htrans", {30'b0, htrans_o}, 32'd0);
        chk("err_first_hsel", {31'b0, hsel_o}, 32'd0);
        chk("err_first_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        hready_i = 1'b1;
        step();
        chk("err_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        hresp_i = 2'b00;
        step();

        // FIFO fill with response stalled, then drain in order
        auto_rd = 1'b1;
        rsp_ready_i = 1'b0;
        push(1'b0, 32'h80100010, 32'h0, 1'b1, 32'hA5000010, 1'b0);
        push(1'b0, 32'h80100020, 32'h0, 1'b1, 32'hA5000020, 1'b0);
        push(1'b1, 32'h80100030, 32'h77, 1'b1, 32'h0, 1'b0);
        chk("fill_ready_low", {31'b0, cmd_ready_o}, 32'd0);
        step(); step(); step(); step(); step();
        chk("fill_ready_held", {31'b0, cmd_ready_o}, 32'd0);
        chk("fill_rsp_held", {31'b0, rsp_valid_o}, 32'd1);
        chk("fill_rsp_rdata_held", rsp_rdata_o, 32'hA5000010);
        b = hs_cyc.size();
        rsp_ready_i = 1'b1;
        push(1'b1, 32'h80100040, 32'h88, 1'b1, 32'h0, 1'b0);
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            step();
            k++;
        end
        chk("fill_drained", 32'(exp_q.size()), 32'd0);
        chk("fill_hs_count", 32'(hs_cyc.size() - b), 32'd4);
        if (hs_cyc.size() >= b + 3) begin
            chk("thru_gap12", 32'(hs_cyc[b+1] - hs_cyc[b]), 32'd4);
            chk("thru_gap23", 32'(hs_cyc[b+2] - hs_cyc[b+1]), 32'd4);
        end
        auto_rd = 1'b0;
        step();

        // Reset during the data phase
        push(1'b1, 32'h80100044, 32'h99, 1'b0, 32'h0, 1'b0);
        step();
        step();
        hready_i = 1'b0;
        step();
        chk("rstmid_hwdata", hwdata_o, 32'h99);
        rst_i = 1'b1;
        step();
        chk("rstmid_hsel", {31'b0, hsel_o}, 32'd0);
        chk("rstmid_htrans", {30'b0, htrans_o}, 32'd0);
        chk("rstmid_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rstmid_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        rst_i = 1'b0;
        hready_i = 1'b1;
        step(); step(); step(); step(); step();
        chk("rstmid_no_rsp", {31'b0, rsp_valid_o}, 32'd0);

        // Slave stuck not-ready
        hready_i = 1'b0;
`ifdef PMU_CMD_TIMEOUT_EN
        push(1'b0, 32'h80100050, 32'h0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 64; i++) step();
        chk("tmo_before", {31'b0, rsp_valid_o}, 32'd0);
        step();
        chk("tmo_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("tmo_hsel", {31'b0, hsel_o}, 32'd0);
        chk("tmo_htrans", {30'b0, htrans_o}, 32'd0);
        step();
`else
        push(1'b0, 32'h80100050, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 100; i++) step();
        chk("stuck_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        chk("stuck_hsel", {31'b0, hsel_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
`endif
        hready_i = 1'b1;
        step(); step();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
